// File: rtl/fmini_pkg.sv
// Shared mini-float definitions for the 7-bit unsigned format {exp[6:4], mant[3:0]},
// value = 1.mant * 2^exp. Used by both the float adder and the sequential subtractor.
//  - EXP_W / MAN_W   : field widths
//  - FIELD_*         : bit positions of the exponent and mantissa fields
//  - MD_W            : internal mantissa width, {2'b01, mant}
//  - IDLE..DONE      : shared FSM state encoding
package fmini_pkg;

    localparam int unsigned EXP_W  = 3;
    localparam int unsigned MAN_W  = 4;
    localparam int unsigned WORD_W = EXP_W + MAN_W;
    localparam int unsigned MD_W   = MAN_W + 2;

    localparam int unsigned FIELD_MAN_LO = 0;
    localparam int unsigned FIELD_MAN_HI = MAN_W - 1;
    localparam int unsigned FIELD_EXP_LO = MAN_W;
    localparam int unsigned FIELD_EXP_HI = WORD_W - 1;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] ALIGN = 2'd1;
    localparam logic [1:0] NORM  = 2'd2;
    localparam logic [1:0] DONE  = 2'd3;

endpackage

// File: rtl/subuf7_norm_seq_if.sv
// Operand/result handshake bundle for the mini-float subtractor.
//  master : producer/consumer side (drives in_valid, a, b, out_ready)
//  slave  : subtractor side (drives in_ready, out_valid, c, zero, neg, unf)
interface subuf7_norm_seq_if;
    import fmini_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [WORD_W-1:0] a;
    logic [WORD_W-1:0] b;
    logic              out_valid;
    logic              out_ready;
    logic [WORD_W-1:0] c;
    logic              zero;
    logic              neg;
    logic              unf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, c, zero, neg, unf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, c, zero, neg, unf
    );

endinterface

// File: rtl/fmini_align_sub.sv
// Combinational alignment and subtraction stage.
//  a, b : minuend / subtrahend words
//  md   : {01,ma} - ({01,mb} >> (ea-eb)), truncated, meaningful only when neg=0
//  ec   : result exponent before normalization (ea)
//  neg  : a < b (the format is monotonic, so a plain unsigned compare suffices)
module fmini_align_sub
    import fmini_pkg::*;
(
    input  logic [WORD_W-1:0] a,
    input  logic [WORD_W-1:0] b,
    output logic [MD_W-1:0]   md,
    output logic [EXP_W-1:0]  ec,
    output logic              neg
);

    logic [EXP_W-1:0] ea;
    logic [EXP_W-1:0] eb;
    logic [EXP_W-1:0] diff;
    logic [MD_W-1:0]  ma_ext;
    logic [MD_W-1:0]  mb_ext;
    logic [MD_W-1:0]  sh_mb;

    always_comb begin
        ea     = a[FIELD_EXP_HI:FIELD_EXP_LO];
        eb     = b[FIELD_EXP_HI:FIELD_EXP_LO];
        ma_ext = {2'b01, a[FIELD_MAN_HI:FIELD_MAN_LO]};
        mb_ext = {2'b01, b[FIELD_MAN_HI:FIELD_MAN_LO]};
        neg    = (a < b);
        // ea >= eb whenever the result is used, so the wrap case is irrelevant.
        diff   = ea - eb;
        if (diff > EXP_W'(MAN_W + 1)) begin
            sh_mb = '0;
        end else begin
            sh_mb = mb_ext >> diff;
        end
        md = ma_ext - sh_mb;
        ec = ea;
    end

endmodule

// File: rtl/subuf7_norm_seq.sv
// Sequential mini-float subtractor c = a - b.
//  clk  : rising-edge clock
//  rst  : synchronous active-high reset, aborts any operation in flight
//  bus  : slave side of subuf7_norm_seq_if (in_valid/in_ready, a, b,
//         out_valid/out_ready, c, zero, neg, unf)
// Flow: IDLE -> ALIGN (1 cycle) -> NORM (1 left shift per cycle) -> DONE -> IDLE.
module subuf7_norm_seq
    import fmini_pkg::*;
(
    input logic              clk,
    input logic              rst,
    subuf7_norm_seq_if.slave bus
);

    logic [1:0]        state_q, state_d;
    logic [WORD_W-1:0] a_q, a_d;
    logic [WORD_W-1:0] b_q, b_d;
    logic [MD_W-1:0]   md_q, md_d;
    logic [EXP_W-1:0]  ec_q, ec_d;
    logic [WORD_W-1:0] c_q, c_d;
    logic              zero_q, zero_d;
    logic              neg_q, neg_d;
    logic              unf_q, unf_d;

    logic [MD_W-1:0]   al_md;
    logic [EXP_W-1:0]  al_ec;
    logic              al_neg;

    fmini_align_sub u_align (
        .a   (a_q),
        .b   (b_q),
        .md  (al_md),
        .ec  (al_ec),
        .neg (al_neg)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        md_d    = md_q;
        ec_d    = ec_q;
        c_d     = c_q;
        zero_d  = zero_q;
        neg_d   = neg_q;
        unf_d   = unf_q;
        case (state_q)
            IDLE: begin
                if (bus.in_valid) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    c_d     = '0;
                    zero_d  = 1'b0;
                    neg_d   = 1'b0;
                    unf_d   = 1'b0;
                    state_d = ALIGN;
                end
            end
            ALIGN: begin
                if (al_neg) begin
                    neg_d   = 1'b1;
                    c_d     = '0;
                    state_d = DONE;
                end else begin
                    md_d    = al_md;
                    ec_d    = al_ec;
                    state_d = NORM;
                end
            end
            NORM: begin
                if (md_q == '0) begin
                    zero_d  = 1'b1;
                    c_d     = '0;
                    state_d = DONE;
                end else if (md_q[MAN_W]) begin
                    c_d     = {ec_q, md_q[MAN_W-1:0]};
                    state_d = DONE;
                end else if (ec_q == '0) begin
                    // Exponent exhausted before the hidden bit surfaced: flush.
                    unf_d   = 1'b1;
                    c_d     = '0;
                    state_d = DONE;
                end else begin
                    md_d = {md_q[MD_W-2:0], 1'b0};
                    ec_d = ec_q - EXP_W'(1);
                end
            end
            DONE: begin
                if (bus.out_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            md_q    <= '0;
            ec_q    <= '0;
            c_q     <= '0;
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            unf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            md_q    <= md_d;
            ec_q    <= ec_d;
            c_q     <= c_d;
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            unf_q   <= unf_d;
        end
    end

    assign bus.in_ready  = (state_q == IDLE) && !rst;
    assign bus.out_valid = (state_q == DONE);
    assign bus.c         = c_q;
    assign bus.zero      = zero_q;
    assign bus.neg       = neg_q;
    assign bus.unf       = unf_q;

endmodule

// File: tb/tb_subuf7_norm_seq.sv
// Directed bench for subuf7_norm_seq: each task drives one scenario and checks
// c, flags, handshake and latency (cycle 0 = accept cycle) against hand-worked values.
module tb_subuf7_norm_seq;

    logic clk;
    logic rst;
    int   n_tests;
    int   n_fail;

    subuf7_norm_seq_if bus ();

    subuf7_norm_seq dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Issue one operation and return the cycle in which out_valid first rises
    // (bounded; a hang shows up as a latency mismatch).
    task automatic run_op(input logic [6:0] av, input logic [6:0] bv, output int cyc);
        bus.in_valid = 1'b1;
        bus.a        = av;
        bus.b        = bv;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        cyc          = 1;
        while (!bus.out_valid && cyc < 40) begin
            @(posedge clk);
            #1;
            cyc++;
        end
    endtask

    task automatic release_result();
        bus.out_ready = 1'b1;
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.c !== 7'b0 || bus.in_ready !== 1'b0 ||
            {bus.zero, bus.neg, bus.unf} !== 3'b000) begin
            n_fail++;
            $display("FAIL reset_outputs: got ov=%b c=%b rdy=%b flags=%b%b%b, want 0/0000000/0/000",
                     bus.out_valid, bus.c, bus.in_ready, bus.zero, bus.neg, bus.unf);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_release_ready: got %b want 1", bus.in_ready);
        end
    endtask

    task automatic test_norm_one_shift();
        int cyc;
        // md = 011000 - 001100 = 001100, one shift -> 011000, ec 5->4
        run_op(7'b1011000, 7'b1001000, cyc);
        n_tests++;
        if (cyc !== 4) begin
            n_fail++;
            $display("FAIL norm1_latency: got cycle %0d want 4", cyc);
        end
        n_tests++;
        if (bus.c !== 7'b1001000 || {bus.zero, bus.neg, bus.unf} !== 3'b000) begin
            n_fail++;
            $display("FAIL norm1_result: got c=%b flags=%b%b%b want c=1001000 flags=000",
                     bus.c, bus.zero, bus.neg, bus.unf);
        end
        release_result();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL norm1_release: got ov=%b rdy=%b want ov=0 rdy=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_zero();
        int cyc;
        run_op(7'b0110101, 7'b0110101, cyc);
        n_tests++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL zero_latency: got cycle %0d want 3", cyc);
        end
        n_tests++;
        if (bus.c !== 7'b0 || {bus.zero, bus.neg, bus.unf} !== 3'b100) begin
            n_fail++;
            $display("FAIL zero_result: got c=%b flags=%b%b%b want c=0000000 flags=100",
                     bus.c, bus.zero, bus.neg, bus.unf);
        end
        release_result();
    endtask

    task automatic test_underflow();
        int cyc;
        // md = 010000 - 001111 = 000001, ec=2; two shifts drain ec to 0
        run_op(7'b0100000, 7'b0011111, cyc);
        n_tests++;
        if (cyc !== 5) begin
            n_fail++;
            $display("FAIL unf_latency: got cycle %0d want 5", cyc);
        end
        n_tests++;
        if (bus.c !== 7'b0 || {bus.zero, bus.neg, bus.unf} !== 3'b001) begin
            n_fail++;
            $display("FAIL unf_result: got c=%b flags=%b%b%b want c=0000000 flags=001",
                     bus.c, bus.zero, bus.neg, bus.unf);
        end
        release_result();
    endtask

    task automatic test_neg();
        int cyc;
        run_op(7'b1001000, 7'b1011000, cyc);
        n_tests++;
        if (cyc !== 2) begin
            n_fail++;
            $display("FAIL neg_latency: got cycle %0d want 2", cyc);
        end
        n_tests++;
        if (bus.c !== 7'b0 || {bus.zero, bus.neg, bus.unf} !== 3'b010) begin
            n_fail++;
            $display("FAIL neg_result: got c=%b flags=%b%b%b want c=0000000 flags=010",
                     bus.c, bus.zero, bus.neg, bus.unf);
        end
        release_result();
    endtask

    task automatic test_large_diff();
        int cyc;
        // exponent gap 7 > 5: subtrahend shifts out entirely
        run_op(7'b1110000, 7'b0000000, cyc);
        n_tests++;
        if (cyc !== 3) begin
            n_fail++;
            $display("FAIL bigdiff_latency: got cycle %0d want 3", cyc);
        end
        n_tests++;
        if (bus.c !== 7'b1110000 || {bus.zero, bus.neg, bus.unf} !== 3'b000) begin
            n_fail++;
            $display("FAIL bigdiff_result: got c=%b flags=%b%b%b want c=1110000 flags=000",
                     bus.c, bus.zero, bus.neg, bus.unf);
        end
        release_result();
    endtask

    task automatic test_backpressure();
        int cyc;
        run_op(7'b1011000, 7'b1001000, cyc);
        // Offer a new operand while stalled; it must not be taken.
        bus.in_valid = 1'b1;
        bus.a        = 7'b1110000;
        bus.b        = 7'b0000000;
        for (int i = 0; i < 5; i++) begin
            n_tests++;
            if (bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0 || bus.c !== 7'b1001000 ||
                {bus.zero, bus.neg, bus.unf} !== 3'b000) begin
                n_fail++;
                $display("FAIL stall_hold[%0d]: got ov=%b rdy=%b c=%b flags=%b%b%b want 1/0/1001000/000",
                         i, bus.out_valid, bus.in_ready, bus.c, bus.zero, bus.neg, bus.unf);
            end
            @(posedge clk);
            #1;
        end
        bus.in_valid = 1'b0;
        release_result();
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL stall_release: got ov=%b rdy=%b want ov=0 rdy=1",
                     bus.out_valid, bus.in_ready);
        end
    endtask

    task automatic test_reset_mid_op();
        bus.in_valid = 1'b1;
        bus.a        = 7'b0100000;
        bus.b        = 7'b0011111;
        @(posedge clk);
        #1;
        bus.in_valid = 1'b0;
        @(posedge clk);          // ALIGN -> NORM
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.c !== 7'b0 || bus.unf !== 1'b0 ||
            bus.in_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_outputs: got ov=%b c=%b unf=%b rdy=%b want 0/0000000/0/0",
                     bus.out_valid, bus.c, bus.unf, bus.in_ready);
        end
        rst = 1'b0;
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL midreset_idle: got rdy=%b want 1", bus.in_ready);
        end
        // Aborted op must leave no trace: nothing appears later either.
        repeat (6) @(posedge clk);
        #1;
        n_tests++;
        if (bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL midreset_no_result: got ov=%b want 0", bus.out_valid);
        end
    endtask

    task automatic test_back_to_back();
        int cyc;
        bus.out_ready = 1'b1;
        run_op(7'b1110000, 7'b0000000, cyc);
        n_tests++;
        if (cyc !== 3 || bus.c !== 7'b1110000) begin
            n_fail++;
            $display("FAIL b2b_first: got cycle %0d c=%b want cycle 3 c=1110000", cyc, bus.c);
        end
        @(posedge clk);
        #1;
        n_tests++;
        if (bus.in_ready !== 1'b1 || bus.out_valid !== 1'b0) begin
            n_fail++;
            $display("FAIL b2b_gap: got rdy=%b ov=%b want rdy=1 ov=0", bus.in_ready, bus.out_valid);
        end
        run_op(7'b1001000, 7'b1011000, cyc);
        n_tests++;
        if (cyc !== 2 || bus.c !== 7'b0 || {bus.zero, bus.neg, bus.unf} !== 3'b010) begin
            n_fail++;
            $display("FAIL b2b_second: got cycle %0d c=%b flags=%b%b%b want cycle 2 c=0 flags=010",
                     cyc, bus.c, bus.zero, bus.neg, bus.unf);
        end
        @(posedge clk);
        #1;
        bus.out_ready = 1'b0;
        n_tests++;
        if (bus.out_valid !== 1'b0 || bus.in_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL b2b_end: got ov=%b rdy=%b want ov=0 rdy=1", bus.out_valid, bus.in_ready);
        end
    endtask

    initial begin
        n_tests       = 0;
        n_fail        = 0;
        rst           = 1'b1;
        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b0;
        @(posedge clk);
        #1;
        test_reset();
        test_norm_one_shift();
        test_zero();
        test_underflow();
        test_neg();
        test_large_diff();
        test_backpressure();
        test_reset_mid_op();
        test_back_to_back();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
